// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the IF/EX requesters, the memory and the bus arbiter.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_bus_arbiter_if;
    logic [1:0] req;
    logic       rw0;
    logic       rw1;
    logic       MFC;
    logic [1:0] gnt;
    logic       mem_EN;
    logic       mem_RW;
    logic       MDR_EN_read;
    logic [1:0] ack;
    logic [1:0] err;
    logic       busy;

    modport slave (
        input  req, rw0, rw1, MFC,
        output gnt, mem_EN, mem_RW, MDR_EN_read, ack, err, busy
    );

    modport master (
        output req, rw0, rw1, MFC,
        input  gnt, mem_EN, mem_RW, MDR_EN_read, ack, err, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter for the shared MAR/MDR/memory path (0 = fetch, 1 = execute).
// Sequences mem_EN/mem_RW, waits for MFC with a timeout, and pulses ack or err.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        COMPLETE = 3'd3,
        ABORT    = 3'd4,
        RELEASE  = 3'd5
    } state_t;

    state_t        state_r;
    logic [CW-1:0] count_r;
    logic          owner_r;
    logic          rw_r;
    logic          last_served_r;
    logic [1:0]    gnt_r;
    logic          mem_en_r;
    logic          mem_rw_r;
    logic          mdr_en_read_r;
    logic [1:0]    ack_r;
    logic [1:0]    err_r;
    logic          busy_r;

    logic          owner_s;
    logic          rw_sel_s;

    // Arbitration choice: sole requester wins, a tie goes to the one not served last.
    always_comb begin
        owner_s  = 1'b0;
        rw_sel_s = 1'b0;
        if (bus.req[0] && (!bus.req[1] || last_served_r)) begin
            owner_s  = 1'b0;
            rw_sel_s = bus.rw0;
        end else begin
            owner_s  = 1'b1;
            rw_sel_s = bus.rw1;
        end
    end

    // Transaction FSM with all bus outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            count_r       <= '0;
            owner_r       <= 1'b0;
            rw_r          <= 1'b0;
            last_served_r <= 1'b1;
            gnt_r         <= 2'b00;
            mem_en_r      <= 1'b0;
            mem_rw_r      <= 1'b0;
            mdr_en_read_r <= 1'b0;
            ack_r         <= 2'b00;
            err_r         <= 2'b00;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req != 2'b00) begin
                        owner_r       <= owner_s;
                        rw_r          <= rw_sel_s;
                        last_served_r <= owner_s;
                        gnt_r         <= owner_s ? 2'b10 : 2'b01;
                        mem_rw_r      <= rw_sel_s;
                        mem_en_r      <= 1'b0;
                        count_r       <= '0;
                        busy_r        <= 1'b1;
                        state_r       <= SETUP;
                    end else begin
                        busy_r        <= 1'b0;
                    end
                end
                SETUP: begin
                    mem_en_r <= 1'b1;
                    count_r  <= '0;
                    state_r  <= ACCESS;
                end
                ACCESS: begin
                    // MFC takes priority over a simultaneous timeout.
                    if (bus.MFC) begin
                        mdr_en_read_r <= rw_r;
                        ack_r         <= gnt_r;
                        state_r       <= COMPLETE;
                    end else if (count_r == CNT_LAST) begin
                        mem_en_r      <= 1'b0;
                        err_r         <= gnt_r;
                        state_r       <= ABORT;
                    end else begin
                        count_r       <= count_r + CNT_ONE;
                    end
                end
                COMPLETE, ABORT: begin
                    gnt_r         <= 2'b00;
                    mem_en_r      <= 1'b0;
                    mem_rw_r      <= 1'b0;
                    mdr_en_read_r <= 1'b0;
                    ack_r         <= 2'b00;
                    err_r         <= 2'b00;
                    state_r       <= RELEASE;
                end
                RELEASE: begin
                    if (!bus.req[owner_r]) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    gnt_r         <= 2'b00;
                    mem_en_r      <= 1'b0;
                    mem_rw_r      <= 1'b0;
                    mdr_en_read_r <= 1'b0;
                    ack_r         <= 2'b00;
                    err_r         <= 2'b00;
                    busy_r        <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.mem_EN      = mem_en_r;
    assign bus.mem_RW      = mem_rw_r;
    assign bus.MDR_EN_read = mdr_en_read_r;
    assign bus.ack         = ack_r;
    assign bus.err         = err_r;
    assign bus.busy        = busy_r;
endmodule
